// File: rtl/rx_bit_sampler.sv
// UART RX oversampling front end: edge/bit counters and 3-sample majority vote; optional RX_NOISE_FLAG_EN adds noise_flag.
// Latency: sampled_bit/sample_done are valid in the cycle edge_cnt==half+1. Backpressure: none; dat_samp_en gates everything.
module rx_bit_sampler #(
    parameter int FRAME_BITS = 11,
    parameter int CNT_W      = 6,
    parameter int BIT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dat_samp_en,
    input  logic [CNT_W-1:0] prescale,
    input  logic             rx_in,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sampled_bit,
    output logic             sample_done
`ifdef RX_NOISE_FLAG_EN
    ,
    output logic             noise_flag
`endif
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last_edge;
    logic             at_wrap;
    logic             at_s0;
    logic             at_s1;
    logic             at_vote;
    logic             s0;
    logic             s1;
    logic             vote;

    assign half      = prescale >> 1;
    assign last_edge = prescale - CNT_W'(1);

    // Equality compare on purpose: a counter already past a newly lowered prescale rolls over naturally.
    assign at_wrap = (edge_cnt == last_edge);
    assign at_s0   = (edge_cnt == half - CNT_W'(2));
    assign at_s1   = (edge_cnt == half - CNT_W'(1));
    assign at_vote = (edge_cnt == half);

    assign vote = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!dat_samp_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (at_wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    // Partial-bit samples are dropped when the enable falls so a restart never votes with stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0          <= 1'b1;
            s1          <= 1'b1;
            sampled_bit <= 1'b1;
            sample_done <= 1'b0;
        end else if (!dat_samp_en) begin
            s0          <= 1'b1;
            s1          <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            if (at_s0) begin
                s0 <= rx_in;
            end
            if (at_s1) begin
                s1 <= rx_in;
            end
            if (at_vote) begin
                sampled_bit <= vote;
            end
            sample_done <= at_vote;
        end
    end

`ifdef RX_NOISE_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noise_flag <= 1'b0;
        end else if (!dat_samp_en) begin
            noise_flag <= 1'b0;
        end else if (at_vote) begin
            noise_flag <= !((s0 == s1) && (s1 == rx_in));
        end
    end
`endif

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: cycle-count model checked every cycle plus hand-computed directed expectations.
module tb_rx_bit_sampler;

    localparam int FB = 11;
    localparam int CW = 6;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rx;
    logic [CW-1:0] prescale;
    logic [CW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          sampled_bit;
    logic          sample_done;
`ifdef RX_NOISE_FLAG_EN
    logic          noise_flag;
`endif

    rx_bit_sampler #(.FRAME_BITS(FB), .CNT_W(CW), .BIT_W(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .dat_samp_en (en),
        .prescale    (prescale),
        .rx_in       (rx),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
`ifdef RX_NOISE_FLAG_EN
        ,
        .noise_flag  (noise_flag)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: n = enabled clocks since the last reset/disable; bit position and vote window follow from n alone.
    int         n;
    logic [1:0] hist;
    logic       m_bit;
    logic       m_done;
    logic       m_noise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n       <= 0;
            hist    <= 2'b11;
            m_bit   <= 1'b1;
            m_done  <= 1'b0;
            m_noise <= 1'b0;
        end else if (!en) begin
            n       <= 0;
            m_done  <= 1'b0;
            m_noise <= 1'b0;
        end else begin
            n    <= n + 1;
            hist <= {hist[0], rx};
            if ((n + 1) % int'(prescale) == int'(prescale) / 2 + 1) begin
                m_bit   <= (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
                m_done  <= 1'b1;
                m_noise <= !((hist[1] == hist[0]) && (hist[0] == rx));
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    logic checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            chk("model edge_cnt", int'(edge_cnt), n % int'(prescale));
            chk("model bit_cnt", int'(bit_cnt), (n / int'(prescale)) % FB);
            chk("model sampled_bit", int'(sampled_bit), int'(m_bit));
            chk("model sample_done", int'(sample_done), int'(m_done));
`ifdef RX_NOISE_FLAG_EN
            chk("model noise_flag", int'(noise_flag), int'(m_noise));
`endif
        end
    end

    task automatic cyc(input logic e, input logic r);
        en = e;
        rx = r;
        @(negedge clk);
    endtask

    int strobes;

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        rx       = 1'b1;
        prescale = 6'd8;
        @(negedge clk);
        @(negedge clk);
        chk("reset edge_cnt", int'(edge_cnt), 0);
        chk("reset bit_cnt", int'(bit_cnt), 0);
        chk("reset sampled_bit", int'(sampled_bit), 1);
        chk("reset sample_done", int'(sample_done), 0);
        rst      = 1'b0;
        checking = 1'b1;

        // Clean zero bit, prescale 8: vote at edge 4, strobe visible at edge 5.
        repeat (4) cyc(1'b1, 1'b0);
        chk("zero pre-strobe done", int'(sample_done), 0);
        cyc(1'b1, 1'b0);
        chk("zero strobe edge", int'(edge_cnt), 5);
        chk("zero strobe done", int'(sample_done), 1);
        chk("zero sampled", int'(sampled_bit), 0);
        cyc(1'b1, 1'b0);
        chk("zero strobe width", int'(sample_done), 0);
        repeat (2) cyc(1'b1, 1'b0);
        chk("zero wrap edge", int'(edge_cnt), 0);
        chk("zero wrap bit", int'(bit_cnt), 1);

        cyc(1'b0, 1'b1);
        prescale = 6'd16;
        cyc(1'b0, 1'b1);

        // Glitch at edge 7 only: samples 1,0,1 -> 1.
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, (k != 7));
            if (k == 8) begin
                chk("glitch edge", int'(edge_cnt), 9);
                chk("glitch done", int'(sample_done), 1);
                chk("glitch sampled", int'(sampled_bit), 1);
`ifdef RX_NOISE_FLAG_EN
                chk("glitch noise", int'(noise_flag), 1);
`endif
            end
        end
        // Low at edges 6 and 8: samples 0,1,0 -> 0.
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, !(k == 6 || k == 8));
            if (k == 8) begin
                chk("majlow sampled", int'(sampled_bit), 0);
                chk("majlow bit_cnt", int'(bit_cnt), 1);
`ifdef RX_NOISE_FLAG_EN
                chk("majlow noise", int'(noise_flag), 1);
`endif
            end
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1);
            if (k == 8) begin
                chk("clean one sampled", int'(sampled_bit), 1);
`ifdef RX_NOISE_FLAG_EN
                chk("clean one noise", int'(noise_flag), 0);
`endif
            end
        end

        cyc(1'b0, 1'b1);
        prescale = 6'd8;
        cyc(1'b0, 1'b1);

        // Full frame: 11 bits of 8 clocks, even bits high.
        strobes = 0;
        for (int i = 0; i < 88; i++) begin
            cyc(1'b1, ((i / 8) % 2 == 0));
            if (sample_done) strobes++;
            if (i == 86) begin
                chk("frame last bit_cnt", int'(bit_cnt), 10);
                chk("frame last edge_cnt", int'(edge_cnt), 7);
            end
        end
        chk("frame strobes", strobes, 11);
        chk("frame wrap bit_cnt", int'(bit_cnt), 0);
        chk("frame wrap edge_cnt", int'(edge_cnt), 0);

        // Enable drop at edge 3 of a low bit; last voted bit (bit 10) was high.
        repeat (3) cyc(1'b1, 1'b0);
        chk("drop pre edge", int'(edge_cnt), 3);
        cyc(1'b0, 1'b0);
        chk("drop edge_cnt", int'(edge_cnt), 0);
        chk("drop bit_cnt", int'(bit_cnt), 0);
        chk("drop done", int'(sample_done), 0);
        chk("drop sampled held", int'(sampled_bit), 1);
        strobes = 0;
        repeat (4) begin
            cyc(1'b0, 1'b0);
            if (sample_done) strobes++;
        end
        chk("drop no strobe", strobes, 0);

        // Async reset mid-frame at bit 4, edge 5.
        repeat (37) cyc(1'b1, 1'b0);
        chk("arst pre bit_cnt", int'(bit_cnt), 4);
        chk("arst pre edge_cnt", int'(edge_cnt), 5);
        chk("arst pre sampled", int'(sampled_bit), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst edge_cnt", int'(edge_cnt), 0);
        chk("arst bit_cnt", int'(bit_cnt), 0);
        chk("arst sampled", int'(sampled_bit), 1);
        chk("arst done", int'(sample_done), 0);
        en = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("rst beats enable", int'(edge_cnt), 0);
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        chk("post rst edge_cnt", int'(edge_cnt), 1);
        chk("post rst bit_cnt", int'(bit_cnt), 0);

        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
- UART receive-side oversampling front end: edge counter, bit counter and 3-sample majority-vote data sampler in one block.
- Sits directly upstream of the start-check, parity-check and stop-check stages. It feeds them `sampled_bit`, and the RX FSM uses `sample_done` and `edge_cnt`/`bit_cnt` to time their enables.

Parameters:
- FRAME_BITS, 11, bits per frame (start + 8 data + parity + stop); bit_cnt wraps after FRAME_BITS-1.
- CNT_W, 6, width of prescale and edge_cnt.
- BIT_W, 4, width of bit_cnt; must satisfy 2^BIT_W >= FRAME_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- dat_samp_en  input  1  sampling/counting enable from RX FSM.
- prescale  input  CNT_W  oversampling ratio; legal values are even numbers 6..32 (8/16/32 in use).
- rx_in  input  1  synchronised serial RX line.
- edge_cnt  output  CNT_W  current oversample edge index within bit.
- bit_cnt  output  BIT_W  current bit index within frame.
- sampled_bit  output  1  majority-voted value of current bit.
- sample_done  output  1  one-cycle strobe: sampled_bit just updated.
- noise_flag  output  1  present only with RX_NOISE_FLAG_EN (see below).

Behaviour:
- Reset (rst=1, async): edge_cnt=0, bit_cnt=0, sampled_bit=1 (idle line level), sample_done=0, internal samples s0=s1=1, noise_flag=0.
- Define half = prescale >> 1.
- Counting, when dat_samp_en=1:
  - edge_cnt increments each clk.
  - When edge_cnt==prescale-1: edge_cnt wraps to 0 next cycle and bit_cnt increments.
  - When bit_cnt==FRAME_BITS-1 and edge_cnt==prescale-1: bit_cnt wraps to 0.
- Enable low: when dat_samp_en=0, edge_cnt and bit_cnt clear to 0 on the next clk. sampled_bit holds its value. sample_done=0.
- Sampling, with dat_samp_en=1:
  - s0 <= rx_in at the edge where edge_cnt==half-2.
  - s1 <= rx_in where edge_cnt==half-1.
  - Where edge_cnt==half: sampled_bit <= majority(s0, s1, rx_in) and sample_done <= 1.
  - Example, prescale=8: samples taken at edges 2, 3, 4.
- Latency: sampled_bit and sample_done are valid during the cycle in which edge_cnt==half+1. sample_done is exactly one cycle wide, once per bit period.
- prescale change: changes are only legal while dat_samp_en=0. If prescale changes mid-bit with enable high, counting continues against the new value. Wrap is detected with a == compare, so if edge_cnt is already above new prescale-1 it counts up to 2^CNT_W-1 and wraps naturally. The bench does not check this case.
- Enable dropping mid-sample: s0/s1 are discarded. No sample_done is issued for the partial bit.
- Simultaneous rst and enable: reset wins.
- Reset mid-frame: all outputs return to reset values asynchronously. Counting resumes from 0 on the first enabled clk after rst deasserts.
- No arithmetic overflow: edge_cnt max 31 < 2^CNT_W.

Optional Feature:
- Macro: RX_NOISE_FLAG_EN.
- Defined:
  - noise_flag port exists.
  - On the sampling edge (edge_cnt==half), noise_flag <= (s0, s1, rx_in not all equal).
  - noise_flag is valid alongside sample_done and holds until the next sampling edge.
  - Cleared by rst and when dat_samp_en=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Clean zero bit: rst pulse, prescale=8, dat_samp_en=1, rx_in=0 for 8 clks -> sample_done high exactly in the cycle edge_cnt==5, sampled_bit=0, edge_cnt wraps 7->0 and bit_cnt 0->1.
- Glitch rejection: prescale=16, rx_in=1 except 0 at edge 7 only -> sampled_bit=1 at edge_cnt==9. With RX_NOISE_FLAG_EN, noise_flag=1.
- Majority low: prescale=16, rx_in=0 at edges 6 and 8, 1 at edge 7 -> sampled_bit=0.
- Frame wrap: prescale=8, enable held for 11*8 clks -> bit_cnt counts 0..10 and returns to 0 at clk 88; exactly 11 sample_done strobes.
- Enable drop: deassert dat_samp_en at edge_cnt==3 (prescale=8) -> next clk edge_cnt=0, bit_cnt=0, no sample_done, sampled_bit unchanged.
- Async reset mid-frame: assert rst between clk edges at bit_cnt=4, edge_cnt=5 -> outputs go to 0/0/1/0 immediately without waiting for a clk edge. After release with enable=1, edge_cnt=1 after the first clk.
